// File: rtl/pipeline_hazard_controller_if.sv
// ============================================================================
// Module   : pipeline_hazard_controller_if
// Brief    : Hazard-unit bundle: Decode/Execute/Memory hazard inputs plus
//            stall, flush, state and performance-counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_controller_if;
    logic [4:0]  iRs1D;
    logic [4:0]  iRs2D;
    logic [4:0]  iDestRegE;
    logic [2:0]  iResultSrcE;
    logic        iRegWriteEnE;
    logic        iBranchTakenE;
    logic        iMemReqM;
    logic        iMemReadyM;
    logic        oStallF;
    logic        oStallD;
    logic        oStallE;
    logic        oStallM;
    logic        oFlushD;
    logic        oFlushE;
    logic [1:0]  oState;
    logic        oTimeout;
    logic [31:0] oStallCycles;
    logic [31:0] oFlushCount;

    modport slave (
        input  iRs1D, iRs2D, iDestRegE, iResultSrcE, iRegWriteEnE,
               iBranchTakenE, iMemReqM, iMemReadyM,
        output oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE,
               oState, oTimeout, oStallCycles, oFlushCount
    );

    modport master (
        output iRs1D, iRs2D, iDestRegE, iResultSrcE, iRegWriteEnE,
               iBranchTakenE, iMemReqM, iMemReadyM,
        input  oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE,
               oState, oTimeout, oStallCycles, oFlushCount
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Five-stage pipeline hazard unit: memory-wait FSM with timeout,
//            load-use stall, branch flush and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_controller #(
    parameter logic [2:0] LOAD_RESULT_SRC = 3'b001,
    parameter int         MEM_TIMEOUT     = 16
) (
    input  wire logic                 iClk,
    input  wire logic                 iRst,
    pipeline_hazard_controller_if.slave hz
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_flag;
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_count;

    logic              mem_stall;
    logic              load_use;
    logic [3:0]        stall_raw;
    logic [1:0]        flush_raw;
    logic [3:0]        stall_out;
    logic [1:0]        flush_out;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_raw  = 4'b0000;
        flush_raw  = 2'b00;
        mem_stall  = ((state == RUN) && hz.iMemReqM && !hz.iMemReadyM) ||
                     ((state == MEM_WAIT) && !hz.iMemReadyM);
        load_use   = hz.iRegWriteEnE && (hz.iResultSrcE == LOAD_RESULT_SRC) &&
                     (hz.iDestRegE != 5'd0) &&
                     ((hz.iDestRegE == hz.iRs1D) || (hz.iDestRegE == hz.iRs2D));

        case (state)
            RUN: begin
                if (mem_stall) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (hz.iMemReadyM)           state_next = RUN;
                else if (wait_cnt == WAIT_LAST) state_next = TIMEOUT;
            end
            TIMEOUT: state_next = TIMEOUT;
            default: state_next = RUN;
        endcase

        // Priority: timeout, then memory stall, then branch, then load-use.
        if (state == TIMEOUT) begin
            stall_raw = 4'b1111;
        end else if (mem_stall) begin
            stall_raw = 4'b1111;
        end else if ((state == RUN) || (state == MEM_WAIT)) begin
            if (hz.iBranchTakenE) begin
                flush_raw = 2'b11;
            end else if (load_use) begin
                stall_raw = 4'b1100;
                flush_raw = 2'b01;
            end
        end
    end

    assign stall_out = iRst ? 4'b0000 : stall_raw;
    assign flush_out = iRst ? 2'b00   : flush_raw;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wait_cnt <= '0;
        end else if ((state == RUN) && (state_next == MEM_WAIT)) begin
            wait_cnt <= '0;
        end else if ((state == MEM_WAIT) && !hz.iMemReadyM && (wait_cnt != WAIT_LAST)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            timeout_flag <= 1'b0;
        end else if (state_next == TIMEOUT) begin
            timeout_flag <= 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if ((|stall_out) && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_out[1] && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end

    assign hz.oStallF      = stall_out[3];
    assign hz.oStallD      = stall_out[2];
    assign hz.oStallE      = stall_out[1];
    assign hz.oStallM      = stall_out[0];
    assign hz.oFlushD      = flush_out[1];
    assign hz.oFlushE      = flush_out[0];
    assign hz.oState       = state;
    assign hz.oTimeout     = timeout_flag;
    assign hz.oStallCycles = stall_cycles;
    assign hz.oFlushCount  = flush_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Directed-vector bench with expected-response queue and monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if hz ();

    pipeline_hazard_controller #(
        .LOAD_RESULT_SRC (3'b001),
        .MEM_TIMEOUT     (4)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .hz   (hz.slave)
    );

    // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, state[1:0], timeout}
    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [8:0] C_IDLE  = 9'b0000_00_00_0;
    localparam logic [8:0] C_LU    = 9'b1100_01_00_0;
    localparam logic [8:0] C_BR    = 9'b0000_11_00_0;
    localparam logic [8:0] C_MS0   = 9'b1111_00_00_0;
    localparam logic [8:0] C_MS1   = 9'b1111_00_01_0;
    localparam logic [8:0] C_W1    = 9'b0000_00_01_0;
    localparam logic [8:0] C_BRW1  = 9'b0000_11_01_0;
    localparam logic [8:0] C_TO    = 9'b1111_00_10_1;
    localparam logic [8:0] C_RSTTO = 9'b0000_00_10_1;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {hz.oStallF, hz.oStallD, hz.oStallE, hz.oStallM,
                   hz.oFlushD, hz.oFlushE, hz.oState, hz.oTimeout};
            n_checks = n_checks + 1;
            if (act !== e.ctl || hz.oStallCycles !== e.sc || hz.oFlushCount !== e.fc) begin
                n_errors = n_errors + 1;
                $display("FAIL %s: ctl=%b sc=%0d fc=%0d, expected ctl=%b sc=%0d fc=%0d",
                         e.name, act, hz.oStallCycles, hz.oFlushCount, e.ctl, e.sc, e.fc);
            end
        end
    end

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] dst, input logic [2:0] src, input logic we,
                         input logic br, input logic req, input logic rdy);
        rst              = r;
        hz.iRs1D         = rs1;
        hz.iRs2D         = rs2;
        hz.iDestRegE     = dst;
        hz.iResultSrcE   = src;
        hz.iRegWriteEnE  = we;
        hz.iBranchTakenE = br;
        hz.iMemReqM      = req;
        hz.iMemReadyM    = rdy;
    endtask

    task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] dst, input logic [2:0] src, input logic we,
                       input logic br, input logic req, input logic rdy,
                       input logic [8:0] ctl, input logic [31:0] sc, input logic [31:0] fc,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        drive(r, rs1, rs2, dst, src, we, br, req, rdy);
        e.ctl  = ctl;
        e.sc   = sc;
        e.fc   = fc;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        drive(1'b1, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        //   rst rs1   rs2   dst   src   we br req rdy  ctl      sc  fc
        cyc(1, 5'd1, 5'd2, 5'd3, 3'd0, 0, 1, 1, 0, C_IDLE,  0, 0, "reset_gates");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  0, 0, "idle");
        cyc(0, 5'd1, 5'd5, 5'd5, 3'd1, 1, 0, 0, 0, C_LU,    0, 0, "load_use_rs2");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  1, 0, "load_use_one_cycle");
        cyc(0, 5'd0, 5'd2, 5'd0, 3'd1, 1, 0, 0, 0, C_IDLE,  1, 0, "x0_load");
        cyc(0, 5'd5, 5'd2, 5'd5, 3'd2, 1, 0, 0, 0, C_IDLE,  1, 0, "non_load_src");
        cyc(0, 5'd5, 5'd2, 5'd5, 3'd1, 0, 0, 0, 0, C_IDLE,  1, 0, "load_no_we");
        cyc(0, 5'd5, 5'd2, 5'd5, 3'd1, 1, 1, 0, 0, C_BR,    1, 0, "branch_over_load");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  1, 1, "after_branch");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS0,   1, 1, "mem_wait_c1");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   2, 1, "mem_wait_c2");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   3, 1, "mem_wait_c3");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 1, C_W1,    4, 1, "mem_ready");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  4, 1, "mem_back_run");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 1, 1, 0, C_MS0,   4, 1, "br_mem_c1");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 1, 1, 0, C_MS1,   5, 1, "br_mem_c2");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 1, 1, 1, C_BRW1,  6, 1, "br_mem_ready");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  6, 2, "br_mem_after");
        cyc(0, 5'd7, 5'd2, 5'd7, 3'd1, 1, 0, 1, 1, C_LU,    6, 2, "ready_req_load_use");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  7, 2, "idle2");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS0,   7, 2, "rstwait_c1");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   8, 2, "rstwait_c2");
        cyc(1, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_W1,    9, 2, "rst_in_wait");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  0, 0, "after_rst_wait");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS0,   0, 0, "to_c1");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   1, 0, "to_c2");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   2, 0, "to_c3");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   3, 0, "to_c4");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, C_MS1,   4, 0, "to_c5");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 1, 0, 1, C_TO,    5, 0, "timeout_entered");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 1, C_TO,    6, 0, "timeout_sticky");
        cyc(1, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_RSTTO, 7, 0, "rst_in_timeout");
        cyc(0, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 0, 0, C_IDLE,  0, 0, "after_rst_timeout");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter LOAD_RESULT_SRC, default 3'b001, the iResultSrcE encoding that marks a load in Execute.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of MEM_WAIT cycles before a fatal timeout.
REQ-003 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports iRs1D and iRs2D, input, 5 each, the source registers of the instruction in Decode.
REQ-006 SHALL have ports iDestRegE (input, 5), iResultSrcE (input, 3) and iRegWriteEnE (input, 1), the Execute-stage destination, result source and write enable.
REQ-007 SHALL have port iBranchTakenE, input, 1, a PC redirect resolved in Execute.
REQ-008 SHALL have ports iMemReqM (input, 1), the data-memory access in Memory stage, and iMemReadyM (input, 1), the memory acknowledge.
REQ-009 SHALL have ports oStallF, oStallD, oStallE and oStallM, output, 1 each, hold enables for the Fetch PC and the D/E/M pipeline registers.
REQ-010 SHALL have ports oFlushD and oFlushE, output, 1 each, bubble-insert for the D and E pipeline registers.
REQ-011 SHALL have port oState, output, 2, the current FSM state.
REQ-012 SHALL have port oTimeout, output, 1, a sticky memory-timeout error.
REQ-013 SHALL have ports oStallCycles and oFlushCount, output, 32 each, performance counters.

Function
REQ-014 SHALL implement FSM states RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2; 2'd3 is illegal and SHALL go to RUN on the next edge.
REQ-015 SHALL define memStall = (RUN and iMemReqM and !iMemReadyM) or (MEM_WAIT and !iMemReadyM); it is combinational, in the same cycle.
REQ-016 While memStall is 1, the block SHALL drive oStallF, oStallD, oStallE and oStallM to 1, and oFlushD and oFlushE to 0.
REQ-017 The transition RUN->MEM_WAIT SHALL happen on an edge where memStall is 1.
REQ-018 In MEM_WAIT with iMemReadyM=1, all stalls SHALL deassert in that same cycle, and the next state SHALL be RUN.
REQ-019 The wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ready.
REQ-020 When the wait counter reaches MEM_TIMEOUT-1 without ready, the next state SHALL be TIMEOUT.
REQ-021 In TIMEOUT, all four stalls and oTimeout SHALL be 1 and the flushes 0, and only iRst exits this state.
REQ-022 SHALL define loadUse = iRegWriteEnE and (iResultSrcE==LOAD_RESULT_SRC) and (iDestRegE!=0) and (iDestRegE==iRs1D or iDestRegE==iRs2D).
REQ-023 In RUN without memStall and without iBranchTakenE, loadUse SHALL drive oStallF=1, oStallD=1 and oFlushE=1 for exactly that cycle.
REQ-024 In RUN without memStall, iBranchTakenE SHALL drive oFlushD=1 and oFlushE=1 with no stalls; branch overrides loadUse.
REQ-025 memStall SHALL override both branch and loadUse; a held branch re-applies when the stall lifts.
REQ-026 oStallCycles SHALL increment on each edge where any stall output is 1, saturating at 32'hFFFFFFFF.
REQ-027 oFlushCount SHALL increment on each edge where oFlushD is 1, saturating at all-ones.

Reset
REQ-028 On an edge with iRst=1, the block SHALL set state RUN, wait counter 0, oTimeout 0, oStallCycles 0 and oFlushCount 0, including mid-MEM_WAIT or in TIMEOUT.
REQ-029 While iRst=1, all stall and flush outputs SHALL be 0.

Verification
REQ-030 Load-use: iRegWriteEnE=1, iResultSrcE=3'b001, iDestRegE=5, iRs2D=5 -> oStallF=oStallD=oFlushE=1 for one cycle; oStallCycles=1.
REQ-031 x0 load: same as REQ-030 but with iDestRegE=0 and iRs1D=0 -> no stall and no flush.
REQ-032 Memory wait: iMemReqM=1, ready low for 3 cycles then high -> all stalls 1 for 3 cycles; oState 0,1,1 then 0; oStallCycles=3.
REQ-033 Branch plus memStall: iBranchTakenE=1 with memStall for 2 cycles, then ready -> flushes 0 for 2 cycles, then oFlushD=oFlushE=1; oFlushCount=1.
REQ-034 Timeout: MEM_TIMEOUT=4, ready never asserted -> TIMEOUT with oTimeout=1 after 5 edges; iRst pulse -> RUN, counters 0.
REQ-035 Reset in MEM_WAIT: iRst during a wait -> next cycle oState=0, all outputs 0.
